// File: rtl/qeciphy_pkg.sv
// Shared constants, trailer field positions, TX state enum and
// the CRC-16-CCITT step function used by the QECIPHY TX framer.
package qeciphy_pkg;

    localparam logic [15:0] FAP        = 16'hF4C5;
    localparam logic [63:0] TRAIN_WORD = 64'hBC50_BC50_BC50_BC50;

    localparam int TRL_FAP_LSB = 48;
    localparam int TRL_MAP_LSB = 40;
    localparam int TRL_PD_ACK  = 38;
    localparam int TRL_PD_REQ  = 37;
    localparam int TRL_RX_RDY  = 36;
    localparam int TRL_SEQ_LSB = 32;
    localparam int TRL_CRC_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRAIN = 2'd1,
        ST_RUN   = 2'd2
    } tx_state_e;

    // Poly 0x1021, MSB of the word first, no reflection.
    function automatic logic [15:0] crc16_ccitt_64(
        input logic [15:0] crc,
        input logic [63:0] word
    );
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 63; i >= 0; i--) begin
            fb = c[15] ^ word[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

endpackage

// File: rtl/qeciphy_crc16_64.sv
// Registered CRC-16-CCITT accumulator, one 64-bit word per cycle.
// Clear has priority over enable and reloads 16'hFFFF.
module qeciphy_crc16_64
    import qeciphy_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [63:0] i_data,
    output logic [15:0] o_crc
);

    logic [15:0] r_crc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc <= 16'hFFFF;
        end else if (i_clr) begin
            r_crc <= 16'hFFFF;
        end else if (i_en) begin
            r_crc <= crc16_ccitt_64(r_crc, i_data);
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/qeciphy_tx_framer.sv
// QECIPHY TX channel framer: training, payload slots, trailer.
// CRC insertion is built only when QECIPHY_TX_CRC_EN is defined.
module qeciphy_tx_framer
    import qeciphy_pkg::*;
#(
    parameter int FRAME_LEN = 8,
    parameter int TRAIN_LEN = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_enable,
    input  logic [63:0] i_data,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_rx_rdy,
    input  logic        i_pd_req,
    input  logic        i_pd_ack,
    output logic [63:0] o_tx_data,
    output logic        o_training,
    output logic        o_frame_end
);

    localparam int TW = $clog2(TRAIN_LEN + 1);
    localparam logic [3:0]    LAST_SLOT = 4'(FRAME_LEN);
    localparam logic [TW-1:0] LAST_TRN  = TW'(TRAIN_LEN - 1);

    tx_state_e     r_state;
    logic [3:0]    r_slot;
    logic [TW-1:0] r_train_cnt;
    logic [3:0]    r_seq;
    logic [7:0]    r_bitmap;

    logic        w_pay;
    logic        w_hs;
    logic [63:0] w_word;
    logic [15:0] w_crc;
    logic [63:0] w_trailer;

    assign w_pay   = (r_state == ST_RUN) && (r_slot < LAST_SLOT)
                     && i_enable;
    assign o_ready = w_pay;
    assign w_hs    = w_pay && i_valid;
    // Empty slots go out as zero and still feed the CRC.
    assign w_word  = w_hs ? i_data : 64'h0;

`ifdef QECIPHY_TX_CRC_EN
    logic w_crc_clr;

    assign w_crc_clr = !i_enable || (r_state != ST_RUN)
                       || (r_slot == LAST_SLOT);

    qeciphy_crc16_64 u_crc (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_crc_clr),
        .i_en   (w_pay),
        .i_data (w_word),
        .o_crc  (w_crc)
    );
`else
    assign w_crc = 16'h0000;
`endif

    always_comb begin
        w_trailer = 64'h0;
        w_trailer[TRL_FAP_LSB +: 16] = FAP;
        w_trailer[TRL_MAP_LSB +: 8]  = r_bitmap;
        w_trailer[TRL_PD_ACK]        = i_pd_ack;
        w_trailer[TRL_PD_REQ]        = i_pd_req;
        w_trailer[TRL_RX_RDY]        = i_rx_rdy;
        w_trailer[TRL_SEQ_LSB +: 4]  = r_seq;
        w_trailer[TRL_CRC_LSB +: 16] = w_crc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_slot      <= 4'd0;
            r_train_cnt <= '0;
            r_seq       <= 4'd0;
            r_bitmap    <= 8'h00;
            o_tx_data   <= 64'h0;
            o_training  <= 1'b0;
            o_frame_end <= 1'b0;
        end else if (!i_enable) begin
            r_state     <= ST_IDLE;
            r_slot      <= 4'd0;
            r_train_cnt <= '0;
            r_seq       <= 4'd0;
            r_bitmap    <= 8'h00;
            o_tx_data   <= 64'h0;
            o_training  <= 1'b0;
            o_frame_end <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_state     <= ST_TRAIN;
                    r_train_cnt <= '0;
                    o_tx_data   <= 64'h0;
                    o_training  <= 1'b0;
                    o_frame_end <= 1'b0;
                end
                ST_TRAIN: begin
                    o_tx_data   <= TRAIN_WORD;
                    o_training  <= 1'b1;
                    o_frame_end <= 1'b0;
                    if (r_train_cnt == LAST_TRN) begin
                        r_state     <= ST_RUN;
                        r_slot      <= 4'd0;
                        r_train_cnt <= '0;
                    end else begin
                        r_train_cnt <= r_train_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    o_training <= 1'b0;
                    if (r_slot < LAST_SLOT) begin
                        o_tx_data   <= w_word;
                        o_frame_end <= 1'b0;
                        r_bitmap[r_slot[2:0]] <= w_hs;
                        r_slot      <= r_slot + 1'b1;
                    end else begin
                        o_tx_data   <= w_trailer;
                        o_frame_end <= 1'b1;
                        r_seq       <= r_seq + 1'b1;
                        r_bitmap    <= 8'h00;
                        r_slot      <= 4'd0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qeciphy_tx_framer.sv
// Directed self-checking bench for qeciphy_tx_framer
// (FRAME_LEN=8, TRAIN_LEN=16); CRC expectation follows QECIPHY_TX_CRC_EN.
module tb_qeciphy_tx_framer;

    localparam int FL = 8;
    localparam int TL = 16;
    localparam logic [63:0] TRN = 64'hBC50_BC50_BC50_BC50;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_enable;
    logic [63:0] i_data;
    logic        i_valid;
    logic        o_ready;
    logic        i_rx_rdy;
    logic        i_pd_req;
    logic        i_pd_ack;
    logic [63:0] o_tx_data;
    logic        o_training;
    logic        o_frame_end;

    int         nvec = 0;
    int         nerr = 0;
    logic [3:0] exp_seq = 4'd0;

    always #5 clk = ~clk;

    qeciphy_tx_framer #(
        .FRAME_LEN (FL),
        .TRAIN_LEN (TL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_enable    (i_enable),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_rx_rdy    (i_rx_rdy),
        .i_pd_req    (i_pd_req),
        .i_pd_ack    (i_pd_ack),
        .o_tx_data   (o_tx_data),
        .o_training  (o_training),
        .o_frame_end (o_frame_end)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] m_crc(
        input logic [15:0] c,
        input logic [63:0] w
    );
        logic [15:0] r;
        logic        x;
        r = c;
        for (int b = 63; b >= 0; b--) begin
            x = r[15] ^ w[b];
            r = r << 1;
            if (x) r = r ^ 16'h1021;
        end
        return r;
    endfunction

    task automatic test_reset;
        rst_n = 1'b0; i_enable = 1'b0; i_valid = 1'b0;
        i_data = 64'h0; i_rx_rdy = 1'b0;
        i_pd_req = 1'b0; i_pd_ack = 1'b0;
        #12;
        nvec++;
        if ({o_tx_data, o_ready, o_training, o_frame_end}
            !== 67'h0) begin
            nerr++;
            $display("FAIL reset got %h/%b%b%b want 0/000",
                     o_tx_data, o_ready, o_training, o_frame_end);
        end
        step; rst_n = 1'b1;
        step; step;
        nvec++;
        if (o_tx_data !== 64'h0 || o_ready !== 1'b0) begin
            nerr++;
            $display("FAIL idle_disabled got %h/%b want 0/0",
                     o_tx_data, o_ready);
        end
    endtask

    task automatic do_training(input string tag);
        i_enable = 1'b1;
        step;
        nvec++;
        if (o_training !== 1'b0 || o_tx_data !== 64'h0) begin
            nerr++;
            $display("FAIL %s idle_exit got %h/%b want 0/0",
                     tag, o_tx_data, o_training);
        end
        for (int k = 0; k < TL; k++) begin
            step;
            nvec++;
            if (o_training !== 1'b1 || o_tx_data !== TRN) begin
                nerr++;
                $display("FAIL %s train%0d got %h/%b want %h/1",
                         tag, k, o_tx_data, o_training, TRN);
            end
            nvec++;
            if (o_ready !== (k == TL - 1)) begin
                nerr++;
                $display("FAIL %s train_rdy%0d got %b want %b",
                         tag, k, o_ready, (k == TL - 1));
            end
        end
    endtask

    task automatic run_frame(
        input string       tag,
        input logic [7:0]  vmask,
        input logic [63:0] d [FL],
        input logic [2:0]  flg
    );
        logic [15:0] c;
        logic [15:0] ecrc;
        logic [63:0] e;
        c = 16'hFFFF;
        for (int s = 0; s < FL; s++) begin
            i_valid  = vmask[s];
            i_data   = d[s];
            i_pd_ack = ~flg[2];
            i_pd_req = ~flg[1];
            i_rx_rdy = ~flg[0];
            #1;
            nvec++;
            if (o_ready !== 1'b1) begin
                nerr++;
                $display("FAIL %s rdy_slot%0d got %b want 1",
                         tag, s, o_ready);
            end
            step;
            e = vmask[s] ? d[s] : 64'h0;
            c = m_crc(c, e);
            nvec++;
            if (o_tx_data !== e || o_frame_end !== 1'b0) begin
                nerr++;
                $display("FAIL %s slot%0d got %h/%b want %h/0",
                         tag, s, o_tx_data, o_frame_end, e);
            end
        end
        i_valid  = 1'b1;
        i_data   = 64'hDEAD_BEEF_DEAD_BEEF;
        i_pd_ack = flg[2];
        i_pd_req = flg[1];
        i_rx_rdy = flg[0];
        #1;
        nvec++;
        if (o_ready !== 1'b0) begin
            nerr++;
            $display("FAIL %s rdy_trailer got %b want 0",
                     tag, o_ready);
        end
        step;
`ifdef QECIPHY_TX_CRC_EN
        ecrc = c;
`else
        ecrc = 16'h0000;
`endif
        e = {16'hF4C5, vmask, 1'b0, flg, exp_seq, 16'h0000, ecrc};
        nvec++;
        if (o_tx_data !== e || o_frame_end !== 1'b1) begin
            nerr++;
            $display("FAIL %s trailer got %h/%b want %h/1",
                     tag, o_tx_data, o_frame_end, e);
        end
        exp_seq = exp_seq + 4'd1;
        i_valid = 1'b0;
    endtask

    task automatic test_full_frame;
        logic [63:0] d [FL];
        for (int s = 0; s < FL; s++) d[s] = 64'(s + 1);
        run_frame("full", 8'hFF, d, 3'b000);
    endtask

    task automatic test_sparse;
        logic [63:0] d [FL];
        for (int s = 0; s < FL; s++) d[s] = 64'h5555;
        d[1] = 64'hA;
        d[5] = 64'hB;
        run_frame("sparse", 8'h22, d, 3'b000);
    endtask

    task automatic test_flags_seq;
        logic [63:0] d [FL];
        for (int f = 0; f < 15; f++) begin
            for (int s = 0; s < FL; s++)
                d[s] = {32'(f * 977 + 3), 32'(s * 40503 + f)};
            run_frame($sformatf("flags%0d", f),
                      8'(8'hA5 ^ f), d, 3'b011);
        end
    endtask

    task automatic test_abort;
        logic [63:0] d [FL];
        for (int s = 0; s < 3; s++) begin
            i_valid = 1'b1;
            i_data  = 64'h1000 + 64'(s);
            step;
            nvec++;
            if (o_tx_data !== 64'h1000 + 64'(s)) begin
                nerr++;
                $display("FAIL abort_slot%0d got %h want %h",
                         s, o_tx_data, 64'h1000 + 64'(s));
            end
        end
        i_enable = 1'b0;
        #1;
        nvec++;
        if (o_ready !== 1'b0) begin
            nerr++;
            $display("FAIL abort_rdy got %b want 0", o_ready);
        end
        for (int k = 0; k < 3; k++) begin
            step;
            nvec++;
            if ({o_tx_data, o_frame_end, o_training, o_ready}
                !== 67'h0) begin
                nerr++;
                $display("FAIL abort_idle%0d got %h/%b%b%b want 0/000",
                         k, o_tx_data, o_frame_end, o_training,
                         o_ready);
            end
        end
        i_valid = 1'b0;
        exp_seq = 4'd0;
        do_training("retrain");
        for (int s = 0; s < FL; s++) d[s] = 64'hC0DE_0000 + 64'(s);
        run_frame("after_abort", 8'hFF, d, 3'b101);
    endtask

    task automatic test_async_reset;
        i_valid = 1'b1;
        i_data  = 64'h77;
        step;
        #2;
        rst_n = 1'b0;
        #1;
        nvec++;
        if ({o_tx_data, o_ready, o_training, o_frame_end}
            !== 67'h0) begin
            nerr++;
            $display("FAIL async_rst got %h/%b%b%b want 0/000",
                     o_tx_data, o_ready, o_training, o_frame_end);
        end
        step;
        rst_n = 1'b1;
        i_valid = 1'b0;
    endtask

    initial begin
        test_reset;
        do_training("train");
        test_full_frame;
        test_sparse;
        test_flags_seq;
        test_abort;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule

// File: doc/qeciphy_tx_framer.md
Name: qeciphy_tx_framer

Overview:
- TX-side channel framer for the QECIPHY link.
- Accepts 64-bit user words over a valid/ready handshake and emits a continuous 64-bit line stream toward the TX gearbox/transceiver.
- Sends a fixed training pattern while the link aligns, then sends frames. Each frame is FRAME_LEN payload slots followed by one trailer word.
- The trailer carries the frame alignment pattern (FAP), a slot-valid bitmap, link-control flags (rx_rdy, pd_req, pd_ack), a sequence number and a CRC. The far-end channel decoder consumes these.

Parameters:
- FRAME_LEN, 8, payload slots per frame (1..8; bitmap field is 8 bits, unused bits are 0).
- TRAIN_LEN, 1024, cycles of training pattern before the first frame (>=2).

Ports:
- clk  input  1  TX clock; all logic is in this domain.
- rst_n  input  1  asynchronous active-low reset.
- i_enable  input  1  link enable; low forces IDLE.
- i_data  input  64  user payload word.
- i_valid  input  1  i_data valid.
- o_ready  output  1  framer accepts i_data this cycle.
- i_rx_rdy  input  1  local receiver ready, advertised to far end.
- i_pd_req  input  1  power-down request, advertised.
- i_pd_ack  input  1  power-down acknowledge, advertised.
- o_tx_data  output  64  line word (registered).
- o_training  output  1  o_tx_data currently holds the training pattern.
- o_frame_end  output  1  o_tx_data currently holds a trailer.

Behaviour:
- Reset values: o_tx_data=0, o_ready=0, o_training=0, o_frame_end=0. State=IDLE, slot=0, train count=0, seq=0, CRC=16'hFFFF.
- States:
  - IDLE: output word 0. Go to TRAIN when i_enable=1.
  - TRAIN: output TRAIN_WORD=64'hBC50_BC50_BC50_BC50 for exactly TRAIN_LEN consecutive output cycles, then go to RUN with slot=0.
  - RUN: slots 0..FRAME_LEN-1 are payload; slot FRAME_LEN is the trailer; then wrap to slot 0.
  - Any state: i_enable=0 means IDLE next cycle. A partial frame is abandoned without a trailer; seq and CRC reset; o_ready drops the same cycle.
- o_ready:
  - Combinational from registered state: 1 only in RUN with slot<FRAME_LEN and i_enable=1.
  - Never depends on i_valid.
- Payload slots:
  - Handshake (i_valid&o_ready): o_tx_data<=i_data, bitmap[slot]<=1.
  - No handshake: o_tx_data<=0, bitmap[slot]<=0. The slot is still consumed, so a frame never stalls.
- Latency: word accepted in cycle N appears on o_tx_data in cycle N+1.
- Trailer layout:
  - [63:48] FAP=16'hF4C5
  - [47:40] bitmap
  - [39] 0
  - [38] pd_ack
  - [37] pd_req
  - [36] rx_rdy
  - [35:32] seq
  - [31:16] 0
  - [15:0] CRC
- Trailer rules: flags are sampled in the trailer-load cycle. After the trailer, seq increments mod 16 (15 wraps to 0), bitmap clears and CRC returns to 16'hFFFF.
- CRC:
  - CRC-16-CCITT, poly 16'h1021, init 16'hFFFF, no reflection, no final XOR.
  - Covers all FRAME_LEN slot words as transmitted (zeros included), MSB first.
  - Updated one 64-bit word per cycle.
- o_training and o_frame_end are registered alongside o_tx_data, so they describe the current o_tx_data.
- Reset mid-operation: outputs return to reset values immediately (async); no partial trailer is emitted.

Optional Feature:
- Macro: QECIPHY_TX_CRC_EN.
- Defined: CRC computed and inserted as above.
- Undefined: CRC logic absent; trailer [15:0]=16'h0000; all other behaviour identical.

Decomposition:
- Shared package qeciphy_pkg holds:
  - FAP and TRAIN_WORD constants
  - trailer field bit-position localparams
  - tx state enum typedef (IDLE, TRAIN, RUN)
  - crc16_ccitt_64 function (16-bit crc in, 64-bit word in, 16-bit out)
- Only one sub-module is natural: qeciphy_crc16_64, a registered CRC accumulator with clear/enable. It is instantiated under QECIPHY_TX_CRC_EN.

Test Plan (FRAME_LEN=8, TRAIN_LEN=16):
- Reset then i_enable=1 -> exactly 16 cycles of 64'hBC50_BC50_BC50_BC50 with o_training=1, then o_ready=1 on the next cycle.
- i_valid=1 continuously with i_data=1..8 -> o_tx_data shows 1..8, then a trailer with [63:48]=16'hF4C5, bitmap 8'hFF, seq 0, CRC matching the model. o_ready=0 in the trailer cycle.
- i_valid only in slots 1 and 5 (data 64'hA, 64'hB) -> payload 0,A,0,0,0,B,0,0; bitmap 8'h22.
- i_rx_rdy=1, i_pd_req=1, i_pd_ack=0 at the trailer cycle -> trailer [38:36]=3'b011. Run 17 frames -> seq goes 0..15 then 0.
- i_enable drops at slot 3 -> next output 0, o_ready=0, no trailer. Re-enable -> full 16-cycle training restarts, seq 0.
- Build without QECIPHY_TX_CRC_EN, same stimulus as the second scenario -> identical stream except trailer [15:0]=16'h0000.
